// File: rtl/add_round_key_seq_if.sv
// Stream bundle for add_round_key_seq.
//   in_valid/in_ready/in_state/in_key : upstream slice stream (state + round-key slice)
//   out_valid/out_ready/out_data      : downstream result stream
//   out_last/out_beat                 : position of out_data within its NB-bit block
//   blk_cnt                           : completed-block counter (wraps)
// slave  = the key-addition engine, master = the surrounding datapath.
interface add_round_key_seq_if #(
    parameter int unsigned NB = 128,
    parameter int unsigned DW = 32
);
    localparam int unsigned BEATS = NB / DW;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_state;
    logic [DW-1:0] in_key;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] out_beat;
    logic [15:0]   blk_cnt;

    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_beat, blk_cnt
    );

    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_data, out_last, out_beat, blk_cnt
    );
endinterface

// File: rtl/add_round_key_seq.sv
// Beat-serial AES AddRoundKey: XORs a DW-bit state slice with the matching
// round-key slice, holds the result in a single output register stage, tracks
// the beat position inside each NB-bit block and counts completed blocks.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort, drops the held beat and restarts at beat 0
//   bus   : slave side of add_round_key_seq_if (slice in, result out)
module add_round_key_seq #(
    parameter int unsigned NB = 128,
    parameter int unsigned DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    add_round_key_seq_if.slave bus
);
    localparam int unsigned BEATS = NB / DW;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] beat_q,  beat_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          last_q,  last_d;
    logic [CW-1:0] obeat_q, obeat_d;
    logic [15:0]   cnt_q,   cnt_d;

    logic          ready_c;
    logic          accept_c;
    logic          hs_c;
    logic          at_last_c;

    // Single output register: space frees up in the same cycle it is drained.
    assign ready_c      = !valid_q || bus.out_ready;
    assign bus.in_ready = ready_c;

    // Handshake qualifiers and end-of-block detect.
    always_comb begin
        accept_c  = bus.in_valid && ready_c && !flush;
        hs_c      = valid_q && bus.out_ready;
        at_last_c = (beat_q == CW'(BEATS - 1));
    end

    // Next-state for beat counter, output stage and block counter.
    always_comb begin
        beat_d  = beat_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        obeat_d = obeat_q;
        cnt_d   = cnt_q;

        if (flush) begin
            // Abort wins over everything, including a departing last beat.
            valid_d = 1'b0;
            beat_d  = '0;
        end else begin
            if (hs_c) begin
                valid_d = 1'b0;
                if (last_q) begin
                    cnt_d = cnt_q + 16'(1);
                end
            end
            // A new beat overwrites a departing one with no bubble.
            if (accept_c) begin
                data_d  = bus.in_state ^ bus.in_key;
                obeat_d = beat_q;
                last_d  = at_last_c;
                valid_d = 1'b1;
                beat_d  = at_last_c ? '0 : beat_q + CW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            obeat_q <= '0;
            cnt_q   <= '0;
        end else begin
            beat_q  <= beat_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            obeat_q <= obeat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.out_beat  = obeat_q;
    assign bus.blk_cnt   = cnt_q;
endmodule

// File: tb/tb_add_round_key_seq.sv
// Self-checking bench for add_round_key_seq: four instances (DW = 8, 16, 32,
// 128) share one clock/reset/flush; expected results are queued per instance
// when a slice is accepted and compared when the result leaves the DUT.
module tb_add_round_key_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    add_round_key_seq_if #(.NB(128), .DW(8))   i8   ();
    add_round_key_seq_if #(.NB(128), .DW(16))  i16  ();
    add_round_key_seq_if #(.NB(128), .DW(32))  i32  ();
    add_round_key_seq_if #(.NB(128), .DW(128)) i128 ();

    add_round_key_seq #(.NB(128), .DW(8))   u8   (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i8.slave));
    add_round_key_seq #(.NB(128), .DW(16))  u16  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i16.slave));
    add_round_key_seq #(.NB(128), .DW(32))  u32  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i32.slave));
    add_round_key_seq #(.NB(128), .DW(128)) u128 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i128.slave));

    typedef struct {
        logic [127:0] data;
        logic         last;
        int           beat;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];
    exp_t q128[$];

    int n_cmp = 0;
    int n_bad = 0;
    int run8 = 0;
    int max_run8 = 0;

    logic [31:0] fexp [4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int sel, input logic [127:0] d, input logic l, input int b);
        exp_t e;
        e.data = d;
        e.last = l;
        e.beat = b;
        case (sel)
            8:       q8.push_back(e);
            16:      q16.push_back(e);
            32:      q32.push_back(e);
            default: q128.push_back(e);
        endcase
    endtask

    task automatic score(input int sel, input logic [127:0] d, input logic l, input int b);
        exp_t e;
        int   sz;
        case (sel)
            8:       sz = q8.size();
            16:      sz = q16.size();
            32:      sz = q32.size();
            default: sz = q128.size();
        endcase
        if (sz == 0) begin
            check($sformatf("dw%0d_unexpected_out", sel), 128'(1), 128'(0));
        end else begin
            case (sel)
                8:       e = q8.pop_front();
                16:      e = q16.pop_front();
                32:      e = q32.pop_front();
                default: e = q128.pop_front();
            endcase
            check($sformatf("dw%0d_data", sel), d, e.data);
            check($sformatf("dw%0d_last", sel), 128'(l), 128'(e.last));
            check($sformatf("dw%0d_beat", sel), 128'(b), 128'(e.beat));
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [127:0] s, input logic [127:0] k);
        case (sel)
            8:       begin i8.in_valid = v;   i8.in_state = s[7:0];    i8.in_key = k[7:0];    end
            16:      begin i16.in_valid = v;  i16.in_state = s[15:0];  i16.in_key = k[15:0];  end
            32:      begin i32.in_valid = v;  i32.in_state = s[31:0];  i32.in_key = k[31:0];  end
            default: begin i128.in_valid = v; i128.in_state = s;       i128.in_key = k;       end
        endcase
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            8:       return i8.in_ready;
            16:      return i16.in_ready;
            32:      return i32.in_ready;
            default: return i128.in_ready;
        endcase
    endfunction

    function automatic logic [127:0] rnd(input int sel);
        case (sel)
            8:       return 128'($urandom & 32'h0000_00ff);
            16:      return 128'($urandom & 32'h0000_ffff);
            32:      return 128'($urandom);
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    // Offer one slice (called at posedge+1), queue its expectation once accepted.
    task automatic send(input int sel, input logic [127:0] s, input logic [127:0] k,
                        input logic [127:0] exp, input logic l, input int b);
        int   n = 0;
        logic ok;
        drive(sel, 1'b1, s, k);
        do begin
            @(negedge clk);
            n++;
            ok = rdy(sel) && !flush;
        end while (!ok && n < 20);
        if (ok) push(sel, exp, l, b);
        else    check($sformatf("dw%0d_send_timeout", sel), 128'(0), 128'(1));
        @(posedge clk);
        #1;
        drive(sel, 1'b0, s, k);
    endtask

    task automatic send_rnd(input int sel, input int b, input logic l);
        logic [127:0] s;
        logic [127:0] k;
        s = rnd(sel);
        k = rnd(sel);
        send(sel, s, k, s ^ k, l, b);
    endtask

    // Output monitors: compare every result that leaves a DUT.
    always @(negedge clk) if (rst_n && i8.out_valid && i8.out_ready)
        score(8, 128'(i8.out_data), i8.out_last, int'(i8.out_beat));
    always @(negedge clk) if (rst_n && i16.out_valid && i16.out_ready)
        score(16, 128'(i16.out_data), i16.out_last, int'(i16.out_beat));
    always @(negedge clk) if (rst_n && i32.out_valid && i32.out_ready)
        score(32, 128'(i32.out_data), i32.out_last, int'(i32.out_beat));
    always @(negedge clk) if (rst_n && i128.out_valid && i128.out_ready)
        score(128, i128.out_data, i128.out_last, int'(i128.out_beat));

    // Longest run of consecutive out_valid cycles on the DW=8 instance.
    always @(negedge clk) begin
        if (i8.out_valid) begin
            run8++;
            if (run8 > max_run8) max_run8 = run8;
        end else begin
            run8 = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] st;
        logic [127:0] ky;
        logic [127:0] s0;
        logic [127:0] k0;
        logic [127:0] s1;
        logic [127:0] k1;

        st   = 128'h00112233445566778899aabbccddeeff;
        ky   = 128'h000102030405060708090a0b0c0d0e0f;
        fexp = '{32'h00102030, 32'h40506070, 32'h8090a0b0, 32'hc0d0e0f0};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(8, 1'b0, '0, '0);
        drive(16, 1'b0, '0, '0);
        drive(32, 1'b0, '0, '0);
        drive(128, 1'b0, '0, '0);
        i8.out_ready   = 1'b1;
        i16.out_ready  = 1'b1;
        i32.out_ready  = 1'b1;
        i128.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 128'(i32.out_valid), 128'(0));
        check("rst_out_data",  128'(i32.out_data),  128'(0));
        check("rst_out_last",  128'(i32.out_last),  128'(0));
        check("rst_out_beat",  128'(i32.out_beat),  128'(0));
        check("rst_blk_cnt",   128'(i32.blk_cnt),   128'(0));
        check("rst_in_ready",  128'(i32.in_ready),  128'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 round 0, DW=32
        for (int i = 0; i < 4; i++)
            send(32, 128'(st[127-32*i -: 32]), 128'(ky[127-32*i -: 32]), 128'(fexp[i]), i == 3, i);
        check("fips_blk_before", 128'(i32.blk_cnt), 128'(0));
        @(posedge clk);
        #1;
        check("fips_blk_after", 128'(i32.blk_cnt), 128'(1));
        check("fips_idle_valid", 128'(i32.out_valid), 128'(0));

        // Backpressure: hold out_ready low 3 cycles after the first output
        s0 = rnd(32);
        k0 = rnd(32);
        s1 = rnd(32);
        k1 = rnd(32);
        send(32, s0, k0, s0 ^ k0, 1'b0, 0);
        i32.out_ready = 1'b0;
        drive(32, 1'b1, s1, k1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_data",  128'(i32.out_data),  s0 ^ k0);
            check("bp_hold_valid", 128'(i32.out_valid), 128'(1));
            check("bp_in_ready",   128'(i32.in_ready),  128'(0));
        end
        @(posedge clk);
        #1;
        i32.out_ready = 1'b1;
        send(32, s1, k1, s1 ^ k1, 1'b0, 1);
        send_rnd(32, 2, 1'b0);
        send_rnd(32, 3, 1'b1);
        @(posedge clk);
        #1;
        check("bp_blk_cnt", 128'(i32.blk_cnt), 128'(2));

        // Flush mid-block: the offered slice during flush must be ignored
        send_rnd(32, 0, 1'b0);
        send_rnd(32, 1, 1'b0);
        flush = 1'b1;
        drive(32, 1'b1, rnd(32), rnd(32));
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(32, 1'b0, '0, '0);
        check("flush_out_valid", 128'(i32.out_valid), 128'(0));
        check("flush_blk_cnt",   128'(i32.blk_cnt),   128'(2));
        // Fresh block restarts at beat 0; flushing its held last beat must not count
        for (int i = 0; i < 4; i++) send_rnd(32, i, i == 3);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_last_blk_cnt", 128'(i32.blk_cnt),   128'(2));
        check("flush_last_valid",   128'(i32.out_valid), 128'(0));
        for (int i = 0; i < 4; i++) send_rnd(32, i, i == 3);
        @(posedge clk);
        #1;
        check("flush_after_blk_cnt", 128'(i32.blk_cnt), 128'(3));

        // Back-to-back blocks, DW=8
        for (int i = 0; i < 48; i++) send_rnd(8, i % 16, (i % 16) == 15);
        @(posedge clk);
        #1;
        check("b2b_blk_cnt",   128'(i8.blk_cnt), 128'(3));
        check("b2b_valid_run", 128'(max_run8),   128'(48));

        // Async reset mid-block, DW=16
        for (int i = 0; i < 5; i++) send_rnd(16, i, 1'b0);
        i16.out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(i16.out_valid), 128'(0));
        check("arst_out_data",  128'(i16.out_data),  128'(0));
        check("arst_out_last",  128'(i16.out_last),  128'(0));
        check("arst_out_beat",  128'(i16.out_beat),  128'(0));
        check("arst_blk_cnt",   128'(i16.blk_cnt),   128'(0));
        check("arst_in_ready",  128'(i16.in_ready),  128'(1));
        q16.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i16.out_ready = 1'b1;
        send_rnd(16, 0, 1'b0);
        @(posedge clk);
        #1;

        // DW=128: every beat is last; preload 0xFFFF blocks then wrap
        for (int i = 0; i < 3; i++) send_rnd(128, 0, 1'b1);
        @(posedge clk);
        #1;
        check("w_blk_cnt3", 128'(i128.blk_cnt), 128'(3));
        for (int i = 3; i < 65535; i++) send_rnd(128, 0, 1'b1);
        @(posedge clk);
        #1;
        check("w_blk_cnt_ffff", 128'(i128.blk_cnt), 128'(16'hffff));
        send_rnd(128, 0, 1'b1);
        @(posedge clk);
        #1;
        check("w_blk_cnt_wrap", 128'(i128.blk_cnt), 128'(0));

        repeat (2) @(posedge clk);
        check("sb_drain", 128'(q8.size() + q16.size() + q32.size() + q128.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/add_round_key_seq.md
# add_round_key_seq

Sequential, parametrised AddRoundKey engine for the AES datapath. It accepts the state and the matching round-key slice DW bits per beat over a valid/ready stream and XORs them. It presents the result from a registered output stage, tracks beat position within each NB-bit block, flags the last beat, and counts completed blocks. It sits between the state-array datapath (upstream) and SubBytes/output logic (downstream), and lets narrow byte- or word-serial datapaths reuse one key-addition unit.

## Interface
- NB, 128, block width in bits; fixed for AES, do not change.
- DW, 32, slice width per beat; legal values 8, 16, 32, 64, 128 (must divide NB).
- BEATS (localparam), NB/DW, beats per block.
- CW (localparam), clog2(BEATS), or 1 when BEATS=1; beat index width.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: drop the held output beat and restart at beat 0.
- in_valid  in  1  upstream slice valid.
- in_ready  out  1  block can accept a slice this cycle.
- in_state  in  DW  state slice.
- in_key  in  DW  round-key slice for the same byte positions.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DW  in_state ^ in_key, registered.
- out_last  out  1  out_data is the final beat of a block.
- out_beat  out  CW  beat index of out_data within its block.
- blk_cnt  out  16  number of blocks whose last beat has left; wraps.

## Operation
- Beat order is most significant first: beat 0 carries bits [NB-1:NB-DW]. The block itself only counts beats.
- Input accept: in_valid && in_ready && !flush.
- Output handshake: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational, which gives full throughput with one output register.
- On accept:
  - out_data <= in_state ^ in_key.
  - out_beat <= beat.
  - out_last <= (beat == BEATS-1).
  - out_valid <= 1.
  - beat <= (beat == BEATS-1) ? 0 : beat+1.
- Output handshake with no accept in the same cycle: out_valid <= 0. out_data, out_last and out_beat keep their values.
- Output handshake with out_last=1: blk_cnt <= blk_cnt+1. It wraps 0xFFFF -> 0x0000.
- Simultaneous output handshake and accept: the new beat replaces the old one with no bubble. blk_cnt still increments if the departing beat had out_last=1.
- Stall: while out_valid && !out_ready, all of out_data, out_last, out_beat and out_valid stay stable, and in_ready=0.
- flush=1:
  - out_valid <= 0 and beat <= 0.
  - The input is not accepted, even if in_ready is high.
  - blk_cnt is unchanged, and no increment happens that cycle even if out_ready=1.
- BEATS=1 (DW=128): beat stays 0, and out_last=1 on every output.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_last=0, out_beat=0.
  - beat=0, blk_cnt=0.
  - in_ready therefore reads 1.
- Reset mid-block discards any partial block. The next accepted beat is beat 0.

## Timing
- Latency is 1 cycle: a slice accepted at edge N appears on out_data after edge N, with out_valid=1.
- Throughput is 1 beat/cycle while out_ready=1. One block takes BEATS cycles.
- There is no combinational path from in_valid/in_state/in_key to the outputs.
- The only combinational path is out_ready -> in_ready.
- blk_cnt updates on the edge where the last beat's handshake completes.

## Test plan
- FIPS-197 round 0, DW=32, out_ready=1:
  - Stimulus: state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, one beat per cycle.
  - Required: out_data sequence 00102030, 40506070, 8090a0b0, c0d0e0f0.
  - Required: out_beat 0,1,2,3; out_last only on beat 3; blk_cnt 0 -> 1 one cycle after the last output.
- Backpressure, DW=32: hold out_ready=0 for 3 cycles after the first output.
  - Required: out_data stays 00102030 and in_ready=0 for all 3 cycles.
  - Required: after release, the remaining beats arrive in order with no loss or duplication.
- Back-to-back blocks, DW=8: 3 blocks of 16 beats, out_ready=1, in_valid=1 continuously.
  - Required: 48 consecutive out_valid cycles, out_last on beats 15, 31 and 47, final blk_cnt=3.
- Flush mid-block, DW=32: accept 2 beats, assert flush for 1 cycle, then send a fresh block.
  - Required: out_valid=0 the cycle after the flush, the fresh block starts at out_beat=0, and blk_cnt is unchanged by the flush.
- Async reset mid-block, DW=16: drop rst_n between clock edges after 5 beats.
  - Required: all outputs go to 0 immediately and in_ready=1.
  - Required: the next accepted beat reports out_beat=0.
- DW=128 and blk_cnt wrap:
  - Required: every output has out_last=1.
  - Required: after preloading 0xFFFF blocks through the stream, the next block wraps blk_cnt to 0x0000.
